irq_priority_front: RTL and testbench



---
 rtl/irq_priority_front.sv | 119 +++++++++++
 tb/tb_irq_priority_front.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_front.sv
// irq_priority_front
//   Sequential front end for the 8-input priority encoder stage. Raw request
//   levels are edge-detected and latched into a pending register. The
//   highest-index pending line that is not masked is offered as a code on a
//   valid/ready handshake. The pending bit is cleared when the offer is
//   accepted. Sticky overrun flags record events that arrive on a line that
//   is already pending.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_in     raw request levels; a 0->1 transition is an event
//   mask       1 = line blocked from selection (it still latches as pending)
//   out_code   index of the offered request
//   out_valid  offer present
//   out_ready  consumer accepts
//   pending    pending register (status)
//   ovf        sticky per-line overrun flags
//   ovf_clr    clears all ovf bits (a same-edge set wins)
//   state_dbg  current FSM state (0 = IDLE, 1 = PRESENT)
//
// Handshake: a transfer (fire) happens on a rising edge where out_valid and
//   out_ready are both high. Once out_valid is raised, out_code stays stable
//   and out_valid stays high until fire. out_ready is ignored while out_valid
//   is low.

module irq_priority_front #(
  parameter int N      = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      mask,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      pending,
  output logic [N-1:0]      ovf,
  input  logic              ovf_clr,
  output logic [0:0]        state_dbg
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]   state;
  logic [N-1:0] req_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] sel;
  logic         fire;

  // Highest set index wins; returns 0 for an all-zero vector.
  function automatic logic [CODE_W-1:0] hi_index(input logic [N-1:0] v);
    hi_index = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi_index = CODE_W'(i);
    end
  endfunction

  assign rise      = req_in & ~req_d;
  assign fire      = out_valid & out_ready;
  assign sel       = pending & ~mask;
  assign state_dbg = state;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = fire && (out_code == CODE_W'(i));
    end
  end

  // Edge detect, pending and overrun bookkeeping. A rise on the bit being
  // cleared by the current fire is a fresh event: it re-pends the line and
  // does not count as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d   <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      req_d   <= req_in;
      pending <= (pending & ~clr) | rise;
      ovf     <= (ovf_clr ? '0 : ovf) | (rise & pending & ~clr);
    end
  end

  // Offer FSM. The offer is frozen while presenting, regardless of new
  // arrivals or mask changes, so the consumer always sees a stable code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel != '0) begin
            out_code  <= hi_index(sel);
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_front.sv
module tb_irq_priority_front;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic [2:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic [7:0] ovf;
  logic       ovf_clr;
  logic [0:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  irq_priority_front #(.N(8), .CODE_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check handshake and status outputs in one call.
  task automatic chk_all(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] p, input logic [7:0] o);
    chk({tag, ".valid"},   {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".code"},    {5'd0, out_code},  {5'd0, c});
    chk({tag, ".pending"}, pending, p);
    chk({tag, ".ovf"},     ovf, o);
    chk({tag, ".state"},   {7'd0, state_dbg}, {7'd0, v});
  endtask

  logic [2:0] prio_codes [4];
  logic [7:0] prio_pend  [4];

  initial begin
    prio_codes[0] = 3'd7; prio_codes[1] = 3'd5; prio_codes[2] = 3'd3; prio_codes[3] = 3'd1;
    prio_pend[0]  = 8'h2A; prio_pend[1]  = 8'h0A; prio_pend[2]  = 8'h02; prio_pend[3]  = 8'h00;

    rst = 1'b1; req_in = 8'h00; mask = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;

    // Reset / idle
    tick(2);
    chk_all("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_all("idle", 1'b0, 3'd0, 8'h00, 8'h00);
    end

    // Single event on bit 5
    out_ready = 1'b1;
    req_in = 8'h20;
    tick(1);
    chk_all("single.t", 1'b0, 3'd0, 8'h20, 8'h00);
    tick(1);
    chk_all("single.t1", 1'b1, 3'd5, 8'h20, 8'h00);
    tick(1);
    chk_all("single.t2", 1'b0, 3'd5, 8'h00, 8'h00);
    req_in = 8'h00;
    tick(2);
    chk_all("single.quiet", 1'b0, 3'd5, 8'h00, 8'h00);

    // Priority order 7,5,3,1 with one idle cycle between offers
    req_in = 8'hAA;
    tick(1);
    chk_all("prio.latch", 1'b0, 3'd5, 8'hAA, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("prio.valid", {7'd0, out_valid}, 8'h01);
      chk("prio.code",  {5'd0, out_code},  {5'd0, prio_codes[k]});
      tick(1);
      chk("prio.gap",   {7'd0, out_valid}, 8'h00);
      chk("prio.pend",  pending, prio_pend[k]);
    end
    req_in = 8'h00;
    tick(2);

    // Backpressure: offer of code 0 is held while bit 7 arrives
    out_ready = 1'b0;
    req_in = 8'h01;
    tick(1);
    chk_all("bp.latch", 1'b0, 3'd1, 8'h01, 8'h00);
    tick(1);
    chk_all("bp.offer", 1'b1, 3'd0, 8'h01, 8'h00);
    req_in = 8'h81;
    tick(1);
    chk_all("bp.hi_arrives", 1'b1, 3'd0, 8'h81, 8'h00);
    tick(3);
    chk_all("bp.stalled", 1'b1, 3'd0, 8'h81, 8'h00);
    out_ready = 1'b1;
    tick(1);
    chk_all("bp.fire0", 1'b0, 3'd0, 8'h80, 8'h00);
    tick(1);
    chk_all("bp.offer7", 1'b1, 3'd7, 8'h80, 8'h00);
    tick(1);
    chk_all("bp.fire7", 1'b0, 3'd7, 8'h00, 8'h00);
    req_in = 8'h00;
    tick(2);

    // Mask: bit 7 blocked, bit 2 served; unmask releases bit 7
    mask = 8'h80;
    req_in = 8'h84;
    tick(1);
    chk_all("mask.latch", 1'b0, 3'd7, 8'h84, 8'h00);
    tick(1);
    chk_all("mask.offer2", 1'b1, 3'd2, 8'h84, 8'h00);
    tick(1);
    chk_all("mask.fire2", 1'b0, 3'd2, 8'h80, 8'h00);
    tick(3);
    chk_all("mask.blocked", 1'b0, 3'd2, 8'h80, 8'h00);
    mask = 8'h00;
    tick(1);
    chk_all("mask.offer7", 1'b1, 3'd7, 8'h80, 8'h00);
    tick(1);
    chk_all("mask.fire7", 1'b0, 3'd7, 8'h00, 8'h00);
    req_in = 8'h00;
    tick(2);

    // Overrun on bit 4 while pending and masked
    out_ready = 1'b0;
    mask = 8'h10;
    req_in = 8'h10;
    tick(1);
    chk_all("ovf.latch", 1'b0, 3'd7, 8'h10, 8'h00);
    req_in = 8'h00;
    tick(1);
    req_in = 8'h10;
    tick(1);
    chk_all("ovf.set", 1'b0, 3'd7, 8'h10, 8'h10);
    ovf_clr = 1'b1;
    tick(1);
    chk_all("ovf.clr", 1'b0, 3'd7, 8'h10, 8'h00);
    ovf_clr = 1'b0;
    req_in = 8'h00;
    tick(1);
    req_in = 8'h10;
    ovf_clr = 1'b1;
    tick(1);
    chk_all("ovf.set_wins", 1'b0, 3'd7, 8'h10, 8'h10);
    tick(1);
    chk_all("ovf.clr2", 1'b0, 3'd7, 8'h10, 8'h00);
    ovf_clr = 1'b0;
    mask = 8'h00;
    out_ready = 1'b1;
    tick(1);
    chk_all("ovf.offer4", 1'b1, 3'd4, 8'h10, 8'h00);
    tick(1);
    chk_all("ovf.fire4", 1'b0, 3'd4, 8'h00, 8'h00);
    req_in = 8'h00;
    tick(2);

    // Collision: rise on bit 0 on the same edge as fire of code 0
    out_ready = 1'b0;
    req_in = 8'h01;
    tick(1);
    chk_all("col.latch", 1'b0, 3'd4, 8'h01, 8'h00);
    tick(1);
    chk_all("col.offer", 1'b1, 3'd0, 8'h01, 8'h00);
    req_in = 8'h00;
    tick(1);
    req_in = 8'h01;
    out_ready = 1'b1;
    tick(1);
    chk_all("col.fire_rise", 1'b0, 3'd0, 8'h01, 8'h00);
    tick(1);
    chk_all("col.reoffer", 1'b1, 3'd0, 8'h01, 8'h00);
    tick(1);
    chk_all("col.fire", 1'b0, 3'd0, 8'h00, 8'h00);
    req_in = 8'h00;
    tick(2);

    // Reset mid-offer, then a line held high through reset
    out_ready = 1'b0;
    req_in = 8'h08;
    tick(2);
    chk_all("rst.offer", 1'b1, 3'd3, 8'h08, 8'h00);
    rst = 1'b1;
    tick(1);
    chk_all("rst.mid", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;
    tick(1);
    chk_all("rst.held_rise", 1'b0, 3'd0, 8'h08, 8'h00);
    tick(1);
    chk_all("rst.held_offer", 1'b1, 3'd3, 8'h08, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
